// File: rtl/vga_timing_pkg.sv
// Shared timing types, the built-in mode table and the table sanity check.
package vga_timing_pkg;

  localparam int unsigned TIMING_W        = 16;
  localparam int unsigned NUM_TABLE_MODES = 2;
  localparam int unsigned MODE_IDX_W      = (NUM_TABLE_MODES > 1) ? $clog2(NUM_TABLE_MODES) : 1;

  typedef struct packed {
    logic [TIMING_W-1:0] h_visible;
    logic [TIMING_W-1:0] h_front;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_back;
    logic [TIMING_W-1:0] h_total;
    logic [TIMING_W-1:0] v_visible;
    logic [TIMING_W-1:0] v_front;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_back;
    logic [TIMING_W-1:0] v_total;
    logic                h_pol_pos;
    logic                v_pol_pos;
  } vga_timing_t;

  // Entry 0 sits in the low slice, so MODE_TABLE[i] is mode i.
  localparam vga_timing_t [NUM_TABLE_MODES-1:0] MODE_TABLE = {
    vga_timing_t'{h_visible: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
                  h_total: 16'd1056, v_visible: 16'd600, v_front: 16'd1, v_sync: 16'd4,
                  v_back: 16'd23, v_total: 16'd628, h_pol_pos: 1'b1, v_pol_pos: 1'b1},
    vga_timing_t'{h_visible: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
                  h_total: 16'd800, v_visible: 16'd480, v_front: 16'd10, v_sync: 16'd2,
                  v_back: 16'd33, v_total: 16'd525, h_pol_pos: 1'b0, v_pol_pos: 1'b0}
  };

  function automatic bit timing_fits(vga_timing_t t, int unsigned cnt_w);
    longint unsigned lim;
    longint unsigned hsum;
    longint unsigned vsum;
    lim  = 64'd1 << cnt_w;
    hsum = 64'(t.h_visible) + 64'(t.h_front) + 64'(t.h_sync) + 64'(t.h_back);
    vsum = 64'(t.v_visible) + 64'(t.v_front) + 64'(t.v_sync) + 64'(t.v_back);
    return (hsum == 64'(t.h_total)) && (vsum == 64'(t.v_total)) &&
           (t.h_total != '0) && (t.v_total != '0) &&
           (64'(t.h_total) <= lim) && (64'(t.v_total) <= lim);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable and mode request in, counters and flags out.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 11
);
  logic             pix_ce;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             visible;
  logic             blank_n;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
  logic [1:0]       mode_active;

  modport master (
    input  pix_ce, mode_sel,
    output hcount, vcount, visible, blank_n, hsync, vsync, line_start, frame_start,
           mode_active
  );

  modport slave (
    output pix_ce, mode_sel,
    input  hcount, vcount, visible, blank_n, hsync, vsync, line_start, frame_start,
           mode_active
  );
endinterface

// File: rtl/vga_mode_rom.sv
// Combinational mode-index to timing lookup; out-of-table indices fall back to entry 0.
module vga_mode_rom
  import vga_timing_pkg::*;
#(
  parameter vga_timing_t [NUM_TABLE_MODES-1:0] ModeTable = MODE_TABLE
) (
  input  logic [1:0]  mode_i,
  output vga_timing_t timing_o
);

  always_comb begin
    timing_o = ModeTable[0];
    if (32'(mode_i) < NUM_TABLE_MODES) begin
      timing_o = ModeTable[mode_i[MODE_IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode VGA raster timing generator with pixel clock-enable and frame-aligned mode switch.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned NUM_MODES    = 2,
  parameter int unsigned MODE_DEFAULT = 0,
  parameter vga_timing_t [NUM_TABLE_MODES-1:0] ModeTable = MODE_TABLE
) (
  input  logic      clk,
  input  logic      reset,
  vga_timing_gen_if.master bus_io
);

  if (NUM_MODES < 1 || NUM_MODES > NUM_TABLE_MODES || MODE_DEFAULT >= NUM_MODES) begin : g_bad_cfg
    $error("vga_timing_gen: NUM_MODES/MODE_DEFAULT out of range");
  end
  for (genvar i = 0; i < NUM_TABLE_MODES; i++) begin : g_tbl_chk
    localparam int unsigned Idx = i;
    if (!timing_fits(ModeTable[Idx[MODE_IDX_W-1:0]], CNT_W)) begin : g_bad_mode
      $error("vga_timing_gen: mode table entry inconsistent or too large for CNT_W");
    end
  end

  localparam vga_timing_t DefTiming = ModeTable[MODE_DEFAULT[MODE_IDX_W-1:0]];

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]       mode_q, mode_d;
  logic             vis_q, vis_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] hs_start, hs_end, vs_start, vs_end;
  vga_timing_t      cur_t, nxt_t;

  // cur_t sets the wrap limits; nxt_t describes the position being loaded, so flags
  // for the first (0,0) after a switch already use the new mode.
  vga_mode_rom #(.ModeTable(ModeTable)) u_rom_cur (.mode_i(mode_q), .timing_o(cur_t));
  vga_mode_rom #(.ModeTable(ModeTable)) u_rom_nxt (.mode_i(mode_d), .timing_o(nxt_t));

  always_comb begin
    h_wrap = (h_q == CNT_W'(cur_t.h_total - 16'd1));
    v_wrap = (v_q == CNT_W'(cur_t.v_total - 16'd1));
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (bus_io.pix_ce) begin
      if (h_wrap) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_wrap) begin
          v_d  = '0;
          fs_d = 1'b1;
          if (32'(bus_io.mode_sel) < NUM_MODES) begin
            mode_d = bus_io.mode_sel;
          end
        end else begin
          v_d = v_q + CNT_W'(1);
        end
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hs_start = CNT_W'(nxt_t.h_visible + nxt_t.h_front);
    hs_end   = CNT_W'(nxt_t.h_visible + nxt_t.h_front + nxt_t.h_sync);
    vs_start = CNT_W'(nxt_t.v_visible + nxt_t.v_front);
    vs_end   = CNT_W'(nxt_t.v_visible + nxt_t.v_front + nxt_t.v_sync);
    vis_d    = (h_d < CNT_W'(nxt_t.h_visible)) && (v_d < CNT_W'(nxt_t.v_visible));
    hsync_d  = ((h_d >= hs_start) && (h_d < hs_end)) ^ ~nxt_t.h_pol_pos;
    vsync_d  = ((v_d >= vs_start) && (v_d < vs_end)) ^ ~nxt_t.v_pol_pos;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= 2'(MODE_DEFAULT);
      vis_q   <= 1'b1;
      hsync_q <= ~DefTiming.h_pol_pos;
      vsync_q <= ~DefTiming.v_pol_pos;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      vis_q   <= vis_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign bus_io.hcount      = h_q;
  assign bus_io.vcount      = v_q;
  assign bus_io.visible     = vis_q;
  assign bus_io.blank_n     = vis_q;
  assign bus_io.hsync       = hsync_q;
  assign bus_io.vsync       = vsync_q;
  assign bus_io.line_start  = ls_q;
  assign bus_io.frame_start = fs_q;
  assign bus_io.mode_active = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generators (real table mode 0 / mode 1 default, shrunken table) vs. a reference model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NDUT = 3;

  typedef struct { int hv, hf, hs, ht, vv, vf, vs, vt; bit hp, vp; } tm_t;
  typedef struct packed {
    int h; int v; bit vis; bit bn; bit hs; bit vs; bit ls; bit fs; int mode;
  } exp_t;
  typedef struct { int adv; bit ce; int h; int v; bit hs; bit vis; bit ls; } vec_t;

  // Small table so frame wraps and mode switches fit in a short run.
  localparam vga_timing_t SM0 = '{h_visible: 16'd16, h_front: 16'd2, h_sync: 16'd4,
    h_back: 16'd2, h_total: 16'd24, v_visible: 16'd6, v_front: 16'd1, v_sync: 16'd1,
    v_back: 16'd2, v_total: 16'd10, h_pol_pos: 1'b0, v_pol_pos: 1'b0};
  localparam vga_timing_t SM1 = '{h_visible: 16'd20, h_front: 16'd1, h_sync: 16'd5,
    h_back: 16'd2, h_total: 16'd28, v_visible: 16'd8, v_front: 16'd1, v_sync: 16'd1,
    v_back: 16'd2, v_total: 16'd12, h_pol_pos: 1'b1, v_pol_pos: 1'b1};

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [1:0] mode_sel;

  vga_timing_gen_if #(.CNT_W(11)) if0 ();
  vga_timing_gen_if #(.CNT_W(11)) if1 ();
  vga_timing_gen_if #(.CNT_W(11)) if2 ();
  assign if0.pix_ce = pix_ce;  assign if0.mode_sel = mode_sel;
  assign if1.pix_ce = pix_ce;  assign if1.mode_sel = mode_sel;
  assign if2.pix_ce = pix_ce;  assign if2.mode_sel = mode_sel;

  vga_timing_gen u_dut0 (.clk(clk), .reset(reset), .bus_io(if0));
  vga_timing_gen #(.MODE_DEFAULT(1)) u_dut1 (.clk(clk), .reset(reset), .bus_io(if1));
  vga_timing_gen #(.ModeTable({SM1, SM0})) u_dut2 (.clk(clk), .reset(reset), .bus_io(if2));

  always #5 clk = ~clk;

  tm_t  tbl [NDUT][2];
  int   defmode [NDUT];
  int   mh [NDUT], mv [NDUT], mm [NDUT];
  exp_t ob [NDUT];
  exp_t sbq0[$], sbq1[$], sbq2[$];
  int   checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic predict(input int d, input bit rst, input bit ce, input logic [1:0] sel,
                         output exp_t e);
    tm_t t;
    bit  act;
    e = '0;
    if (rst) begin
      mh[d] = 0; mv[d] = 0; mm[d] = defmode[d];
    end else if (ce) begin
      t = tbl[d][mm[d]];
      if (mh[d] == t.ht - 1) begin
        mh[d] = 0;
        e.ls  = 1'b1;
        if (mv[d] == t.vt - 1) begin
          mv[d] = 0;
          e.fs  = 1'b1;
          if (int'(sel) < 2) mm[d] = int'(sel);
        end else mv[d]++;
      end else mh[d]++;
    end
    t      = tbl[d][mm[d]];
    e.h    = mh[d];
    e.v    = mv[d];
    e.mode = mm[d];
    e.vis  = (mh[d] < t.hv) && (mv[d] < t.vv);
    e.bn   = e.vis;
    act    = (mh[d] >= t.hv + t.hf) && (mh[d] < t.hv + t.hf + t.hs);
    e.hs   = t.hp ? act : !act;
    act    = (mv[d] >= t.vv + t.vf) && (mv[d] < t.vv + t.vf + t.vs);
    e.vs   = t.vp ? act : !act;
  endtask

  function automatic exp_t mk(logic [10:0] h, logic [10:0] v, logic vis, logic bn, logic hs,
                              logic vs, logic ls, logic fs, logic [1:0] m);
    exp_t o;
    o.h = int'(h); o.v = int'(v); o.vis = vis; o.bn = bn; o.hs = hs; o.vs = vs;
    o.ls = ls; o.fs = fs; o.mode = int'(m);
    return o;
  endfunction

  task automatic observe(input int d, output exp_t o);
    case (d)
      0: o = mk(if0.hcount, if0.vcount, if0.visible, if0.blank_n, if0.hsync, if0.vsync,
                if0.line_start, if0.frame_start, if0.mode_active);
      1: o = mk(if1.hcount, if1.vcount, if1.visible, if1.blank_n, if1.hsync, if1.vsync,
                if1.line_start, if1.frame_start, if1.mode_active);
      default: o = mk(if2.hcount, if2.vcount, if2.visible, if2.blank_n, if2.hsync, if2.vsync,
                      if2.line_start, if2.frame_start, if2.mode_active);
    endcase
  endtask

  task automatic tick(input bit rst, input bit ce, input logic [1:0] sel);
    exp_t e;
    bit   empty;
    reset = rst; pix_ce = ce; mode_sel = sel;
    for (int d = 0; d < NDUT; d++) begin
      predict(d, rst, ce, sel, e);
      case (d)
        0: sbq0.push_back(e);
        1: sbq1.push_back(e);
        default: sbq2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      observe(d, ob[d]);
      e = '0;
      empty = 1'b0;
      case (d)
        0: if (sbq0.size() == 0) empty = 1'b1; else e = sbq0.pop_front();
        1: if (sbq1.size() == 0) empty = 1'b1; else e = sbq1.pop_front();
        default: if (sbq2.size() == 0) empty = 1'b1; else e = sbq2.pop_front();
      endcase
      checks++;
      if (empty || ob[d] != e) begin
        errors++;
        $display("FAIL sb dut%0d cyc %0d: got h=%0d v=%0d vis=%0b bn=%0b hs=%0b vs=%0b ls=%0b fs=%0b m=%0d, expected h=%0d v=%0d vis=%0b bn=%0b hs=%0b vs=%0b ls=%0b fs=%0b m=%0d",
                 d, cyc, ob[d].h, ob[d].v, ob[d].vis, ob[d].bn, ob[d].hs, ob[d].vs, ob[d].ls,
                 ob[d].fs, ob[d].mode, e.h, e.v, e.vis, e.bn, e.hs, e.vs, e.ls, e.fs, e.mode);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   n, prev, early, ls_prev0, ls_prev1, per0, per1, lo_min, lo_max, hi_min, hi_max;
    int   bad_pulse, hold_bad, prev_h;
    bit   hit;

    tbl[0][0] = '{640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0};
    tbl[0][1] = '{800, 40, 128, 1056, 600, 1, 4, 628, 1'b1, 1'b1};
    tbl[1][0] = tbl[0][0];
    tbl[1][1] = tbl[0][1];
    tbl[2][0] = '{16, 2, 4, 24, 6, 1, 1, 10, 1'b0, 1'b0};
    tbl[2][1] = '{20, 1, 5, 28, 8, 1, 1, 12, 1'b1, 1'b1};
    defmode[0] = 0; defmode[1] = 1; defmode[2] = 0;

    // {advance, ce, hcount, vcount, hsync, visible, line_start} on the real mode-0 instance
    vecs[0] = '{639, 1'b1, 639, 0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1,   1'b1, 640, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16,  1'b1, 656, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{95,  1'b1, 751, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1,   1'b1, 752, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{47,  1'b1, 799, 0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1,   1'b1, 0,   1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{5,   1'b0, 0,   1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{160, 1'b1, 160, 1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; pix_ce = 1'b0; mode_sel = 2'd0;
    tick(1'b1, 1'b0, 2'd0);
    tick(1'b1, 1'b1, 2'd0);
    chk("rst_hcount", ob[0].h, 0);
    chk("rst_vcount", ob[0].v, 0);
    chk("rst_visible", ob[0].vis, 1);
    chk("rst_hsync_m0", ob[0].hs, 1);
    chk("rst_vsync_m0", ob[0].vs, 1);
    chk("rst_line_start", ob[0].ls, 0);
    chk("rst_mode_m1", ob[1].mode, 1);
    chk("rst_hsync_m1", ob[1].hs, 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].adv; k++) tick(1'b0, vecs[i].ce, 2'd0);
      chk($sformatf("vec%0d_h", i), ob[0].h, vecs[i].h);
      chk($sformatf("vec%0d_v", i), ob[0].v, vecs[i].v);
      chk($sformatf("vec%0d_hs", i), ob[0].hs, vecs[i].hs);
      chk($sformatf("vec%0d_vis", i), ob[0].vis, vecs[i].vis);
      chk($sformatf("vec%0d_ls", i), ob[0].ls, vecs[i].ls);
    end

    // Full-rate: line periods and sync windows on both real modes
    ls_prev0 = -1; ls_prev1 = -1; per0 = -1; per1 = -1;
    lo_min = 99999; lo_max = -1; hi_min = 99999; hi_max = -1;
    repeat (2200) begin
      tick(1'b0, 1'b1, 2'd0);
      if (ob[0].ls) begin if (ls_prev0 >= 0) per0 = cyc - ls_prev0; ls_prev0 = cyc; end
      if (ob[1].ls) begin if (ls_prev1 >= 0) per1 = cyc - ls_prev1; ls_prev1 = cyc; end
      if (!ob[0].hs) begin
        if (ob[0].h < lo_min) lo_min = ob[0].h;
        if (ob[0].h > lo_max) lo_max = ob[0].h;
      end
      if (ob[1].hs) begin
        if (ob[1].h < hi_min) hi_min = ob[1].h;
        if (ob[1].h > hi_max) hi_max = ob[1].h;
      end
    end
    chk("line_period_m0", per0, 800);
    chk("line_period_m1", per1, 1056);
    chk("hsync_m0_first", lo_min, 656);
    chk("hsync_m0_last", lo_max, 751);
    chk("hsync_m1_first", hi_min, 840);
    chk("hsync_m1_last", hi_max, 967);

    // Half-rate pixel enable
    ls_prev0 = -1; per0 = -1; bad_pulse = 0; hold_bad = 0;
    for (int k = 0; k < 3400; k++) begin
      prev_h = ob[0].h;
      tick(1'b0, (k % 2) == 0, 2'd0);
      if ((k % 2) != 0) begin
        if (ob[0].ls || ob[0].fs || ob[1].ls || ob[2].ls || ob[2].fs) bad_pulse++;
        if (ob[0].h != prev_h) hold_bad++;
      end
      if (ob[0].ls) begin if (ls_prev0 >= 0) per0 = cyc - ls_prev0; ls_prev0 = cyc; end
    end
    chk("half_rate_line_period", per0, 1600);
    chk("half_rate_pulse_on_ce0", bad_pulse, 0);
    chk("half_rate_hold", hold_bad, 0);

    // Illegal request held across a wrap
    n = 0; hit = 1'b0;
    while (!hit && n < 400) begin tick(1'b0, 1'b1, 2'd3); n++; hit = ob[2].fs; end
    chk("wait_fs_sel3", hit, 1);
    chk("sel3_mode_held", ob[2].mode, 0);
    prev = cyc; n = 0; hit = 1'b0;
    while (!hit && n < 400) begin tick(1'b0, 1'b1, 2'd3); n++; hit = ob[2].fs; end
    chk("sel3_frame_period", cyc - prev, 240);
    chk("sel3_mode_still", ob[2].mode, 0);

    // Mid-frame request for mode 1 takes effect only at the wrap
    n = 0;
    while (ob[2].v != 5 && n < 300) begin tick(1'b0, 1'b1, 2'd0); n++; end
    chk("wait_v5", ob[2].v, 5);
    n = 0; hit = 1'b0; early = 0;
    while (!hit && n < 400) begin
      tick(1'b0, 1'b1, 2'd1); n++; hit = ob[2].fs;
      if (!hit && ob[2].mode != 0) early++;
    end
    chk("switch_fs_seen", hit, 1);
    chk("switch_not_early", early, 0);
    chk("switch_mode_on_fs", ob[2].mode, 1);
    chk("switch_hsync_pos_inactive", ob[2].hs, 0);
    prev = cyc; n = 0; hit = 1'b0;
    while (!hit && n < 400) begin tick(1'b0, 1'b1, 2'd1); n++; hit = ob[2].fs; end
    chk("frame_period_m1", cyc - prev, 336);

    // Reset mid-line, with pix_ce high
    n = 0;
    while (ob[0].h != 300 && n < 1000) begin tick(1'b0, 1'b1, 2'd1); n++; end
    chk("wait_h300", ob[0].h, 300);
    tick(1'b1, 1'b1, 2'd1);
    chk("midrst_h", ob[0].h, 0);
    chk("midrst_v", ob[0].v, 0);
    chk("midrst_vis", ob[0].vis, 1);
    chk("midrst_hs", ob[0].hs, 1);
    chk("midrst_vs", ob[0].vs, 1);
    chk("midrst_ls", ob[0].ls, 0);
    chk("midrst_fs", ob[0].fs, 0);
    chk("midrst_small_mode", ob[2].mode, 0);
    repeat (50) tick(1'b0, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
